enemy_position_buffer: RTL and testbench

Holds the position of every enemy and sequences the per-frame chase update. On each accepted frame start it commands a player-position capture, then walks the enemy slots one per cycle, presenting each stored position as the AI target and writing back the AI's new position. It sits directly upstream and downstream of the monster AI stage. It also provides a combinational read port to the sprite/draw logic.

---
 rtl/enemy_pkg.sv | 75 +++++++
 rtl/enemy_position_buffer_if.sv | 30 +++
 rtl/enemy_position_buffer_move_rate_divider.sv | 38 +++
 rtl/enemy_position_buffer.sv | 160 ++++++++++++++++
 tb/tb_enemy_position_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_pkg.sv
// ============================================================================
// Module      : enemy_pkg
// Description : Shared types and spawn table for the enemy position buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_pkg;

    // Screen coordinate, wide enough for x up to 511.
    typedef logic [8:0] coord_t;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        UPDATE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int c_spawn_count = 16;

    // Spawn x for table entry idx; entries past the table return 0.
    function automatic coord_t spawn_x(input int idx);
        coord_t v;
        case (idx)
            0:       v = 9'd100;
            1:       v = 9'd0;
            2:       v = 9'd49;
            3:       v = 9'd319;
            4:       v = 9'd200;
            5:       v = 9'd10;
            6:       v = 9'd160;
            7:       v = 9'd300;
            8:       v = 9'd20;
            9:       v = 9'd40;
            10:      v = 9'd80;
            11:      v = 9'd120;
            12:      v = 9'd240;
            13:      v = 9'd260;
            14:      v = 9'd280;
            15:      v = 9'd310;
            default: v = 9'd0;
        endcase
        return v;
    endfunction

    // Spawn y for table entry idx; entries past the table return 0.
    function automatic coord_t spawn_y(input int idx);
        coord_t v;
        case (idx)
            0:       v = 9'd104;
            1:       v = 9'd50;
            2:       v = 9'd50;
            3:       v = 9'd10;
            4:       v = 9'd30;
            5:       v = 9'd220;
            6:       v = 9'd120;
            7:       v = 9'd200;
            8:       v = 9'd20;
            9:       v = 9'd200;
            10:      v = 9'd60;
            11:      v = 9'd180;
            12:      v = 9'd100;
            13:      v = 9'd40;
            14:      v = 9'd230;
            15:      v = 9'd239;
            default: v = 9'd0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_position_buffer_if.sv
// ============================================================================
// Module      : enemy_position_buffer_if
// Description : Link between the position buffer (master) and the monster AI
//               stage (slave): capture command, target out, new position in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enemy_position_buffer_if;
    import enemy_pkg::*;

    logic   GET_PLAYER_POS;
    logic   RUN_AI;
    coord_t TARGET_X;
    coord_t TARGET_Y;
    coord_t NEW_ENEMY_X;
    coord_t NEW_ENEMY_Y;

    modport master (
        output GET_PLAYER_POS, RUN_AI, TARGET_X, TARGET_Y,
        input  NEW_ENEMY_X, NEW_ENEMY_Y
    );

    modport slave (
        input  GET_PLAYER_POS, RUN_AI, TARGET_X, TARGET_Y,
        output NEW_ENEMY_X, NEW_ENEMY_Y
    );
endinterface

`default_nettype wire

// File: rtl/enemy_position_buffer_move_rate_divider.sv
// ============================================================================
// Module      : move_rate_divider
// Description : Counts accepted frame starts and emits a go pulse on every
//               MOVE_DIV-th one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_rate_divider #(
    parameter int MOVE_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_frame_start,
    output logic      o_go
);
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(MOVE_DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign o_go = i_frame_start && (r_count == c_last);

    // Advance on each qualified frame start, wrapping at MOVE_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_frame_start) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/enemy_position_buffer.sv
// ============================================================================
// Module      : enemy_position_buffer
// Description : Flip-flop store of enemy positions with a per-frame chase
//               sweep through the monster AI stage and a combinational read
//               port for the draw logic.
//               Optional feature macro: ENEMY_COLLISION_EN (player hit flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_position_buffer
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMIES = 8,
    parameter int MOVE_DIV    = 2,
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239,
    localparam int IDX_W      = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
    input  wire logic             CLOCK_50,
    input  wire logic             RESET_N,
    input  wire logic             FRAME_START,
    input  wire coord_t           PLAYER_X,
    input  wire coord_t           PLAYER_Y,
    enemy_position_buffer_if.master ai,
    input  wire logic [IDX_W-1:0] READ_IDX,
    output coord_t                READ_X,
    output coord_t                READ_Y,
    output logic                  BUSY,
    output logic                  UPDATE_DONE,
    output logic                  PLAYER_HIT
);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ENEMIES - 1);
    localparam coord_t c_x_max = coord_t'(X_MAX);
    localparam coord_t c_y_max = coord_t'(Y_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    coord_t           r_slot_x [NUM_ENEMIES];
    coord_t           r_slot_y [NUM_ENEMIES];
    logic             w_go;
    logic             w_last;
    coord_t           w_cur_x;
    coord_t           w_cur_y;
    coord_t           w_acc_x;
    coord_t           w_acc_y;

    // Frame starts only count while idle, so mid-sweep pulses leave it alone.
    move_rate_divider #(
        .MOVE_DIV(MOVE_DIV)
    ) u_divider (
        .clk          (CLOCK_50),
        .rst_n        (RESET_N),
        .i_frame_start(FRAME_START && (r_state == IDLE)),
        .o_go         (w_go)
    );

    assign w_last  = (r_idx == c_last_idx);
    assign w_cur_x = r_slot_x[r_idx];
    assign w_cur_y = r_slot_y[r_idx];

    // Out-of-range AI results (including 0-1 wrapping to 511) keep the old axis.
    assign w_acc_x = (ai.NEW_ENEMY_X > c_x_max) ? w_cur_x : ai.NEW_ENEMY_X;
    assign w_acc_y = (ai.NEW_ENEMY_Y > c_y_max) ? w_cur_y : ai.NEW_ENEMY_Y;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: capture, one cycle per slot, then a single done cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_next = CAPTURE;
            CAPTURE: w_state_next = UPDATE;
            UPDATE:  if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Slot walker: restarts at capture, steps once per update cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_idx <= '0;
        end else if (r_state == CAPTURE) begin
            r_idx <= '0;
        end else if ((r_state == UPDATE) && !w_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Slot storage: spawn on reset, write back the accepted AI result.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                r_slot_x[i] <= spawn_x(i);
                r_slot_y[i] <= spawn_y(i);
            end
        end else if (r_state == UPDATE) begin
            r_slot_x[r_idx] <= w_acc_x;
            r_slot_y[r_idx] <= w_acc_y;
        end
    end

    assign ai.GET_PLAYER_POS = (r_state == CAPTURE);
    assign ai.RUN_AI         = (r_state == UPDATE);
    assign ai.TARGET_X       = (r_state == UPDATE) ? w_cur_x : r_slot_x[0];
    assign ai.TARGET_Y       = (r_state == UPDATE) ? w_cur_y : r_slot_y[0];
    assign BUSY              = (r_state != IDLE);
    assign UPDATE_DONE       = (r_state == DONE);

    // Draw-side read of stored slots; unused select codes read as zero.
    always_comb begin
        READ_X = '0;
        READ_Y = '0;
        if (int'(READ_IDX) < NUM_ENEMIES) begin
            READ_X = r_slot_x[READ_IDX];
            READ_Y = r_slot_y[READ_IDX];
        end
    end

`ifdef ENEMY_COLLISION_EN
    coord_t r_player_x;
    coord_t r_player_y;
    logic   r_hit;

    // Player latch at capture; hit flag sticky until the next capture.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_player_x <= '0;
            r_player_y <= '0;
            r_hit      <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_player_x <= PLAYER_X;
            r_player_y <= PLAYER_Y;
            r_hit      <= 1'b0;
        end else if ((r_state == UPDATE) &&
                     (w_acc_x == r_player_x) && (w_acc_y == r_player_y)) begin
            r_hit <= 1'b1;
        end
    end

    assign PLAYER_HIT = r_hit;
`else
    logic w_unused_player;

    assign w_unused_player = ^{PLAYER_X, PLAYER_Y};
    assign PLAYER_HIT      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_enemy_position_buffer.sv
// ============================================================================
// Module      : tb_enemy_position_buffer
// Description : Self-checking bench: directed scenarios plus randomized
//               traffic against a sweep-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_position_buffer;
    import enemy_pkg::*;

    localparam int N   = 8;
    localparam int DIV = 2;
    localparam int XM  = 319;
    localparam int YM  = 239;

    logic       clk;
    logic       rst_n;
    logic       fs;
    coord_t     px;
    coord_t     py;
    logic [2:0] ridx;
    coord_t     rx;
    coord_t     ry;
    logic       busy;
    logic       done;
    logic       hit;

    enemy_position_buffer_if ai_if ();

    enemy_position_buffer #(
        .NUM_ENEMIES(N),
        .MOVE_DIV   (DIV),
        .X_MAX      (XM),
        .Y_MAX      (YM)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .FRAME_START(fs),
        .PLAYER_X   (px),
        .PLAYER_Y   (py),
        .ai         (ai_if),
        .READ_IDX   (ridx),
        .READ_X     (rx),
        .READ_Y     (ry),
        .BUSY       (busy),
        .UPDATE_DONE(done),
        .PLAYER_HIT (hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench copy of the spawn table.
    int spx [16] = '{100, 0, 49, 319, 200, 10, 160, 300, 20, 40, 80, 120, 240, 260, 280, 310};
    int spy [16] = '{104, 50, 50, 10, 30, 220, 120, 200, 20, 200, 60, 180, 100, 40, 230, 239};

    // AI stage stand-in: 0 = chase one step per axis, 1 = random, 2 = x+1.
    int mode;
    int rnd_x;
    int rnd_y;
    int ai_px;
    int ai_py;

    function automatic int step_to(input int t, input int p);
        if (t < p) return t + 1;
        if (t > p) return t - 1;
        return t;
    endfunction

    function automatic int ai_x(input int t, input int p, input int r, input int md);
        if (md == 0) return step_to(t, p);
        if (md == 1) return r;
        return (t == 0) ? 511 : (t + 1) & 511;
    endfunction

    function automatic int ai_y(input int t, input int p, input int r, input int md);
        if (md == 0) return step_to(t, p);
        if (md == 1) return r;
        return t;
    endfunction

    always_comb begin
        ai_if.NEW_ENEMY_X = coord_t'(ai_x(int'(ai_if.TARGET_X), ai_px, rnd_x, mode));
        ai_if.NEW_ENEMY_Y = coord_t'(ai_y(int'(ai_if.TARGET_Y), ai_py, rnd_y, mode));
    end

    // Reference model: slot contents plus position on the sweep timeline
    // (0 = idle, 1 = capture, 2..N+1 = slot ph-2 updated, N+2 = done).
    int m_x [N];
    int m_y [N];
    int m_ph;
    int m_div;
    int m_hit;
    int m_px;
    int m_py;
    bit m_valid;

    logic   s_get, s_run, s_busy, s_done, s_hit;
    coord_t s_tx, s_ty, s_rx, s_ry;

    int total;
    int bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int k;
        bit exp_run;
        s_get  = ai_if.GET_PLAYER_POS;
        s_run  = ai_if.RUN_AI;
        s_tx   = ai_if.TARGET_X;
        s_ty   = ai_if.TARGET_Y;
        s_busy = busy;
        s_done = done;
        s_hit  = hit;
        s_rx   = rx;
        s_ry   = ry;
        if (m_valid) begin
            exp_run = (m_ph >= 2) && (m_ph <= N + 1);
            k = exp_run ? m_ph - 2 : 0;
            chk("get_player_pos", 32'(s_get), 32'(m_ph == 1));
            chk("run_ai", 32'(s_run), 32'(exp_run));
            chk("busy", 32'(s_busy), 32'(m_ph != 0));
            chk("update_done", 32'(s_done), 32'(m_ph == N + 2));
            chk("target_x", 32'(s_tx), m_x[k]);
            chk("target_y", 32'(s_ty), m_y[k]);
            chk("read_x", 32'(s_rx), m_x[ridx]);
            chk("read_y", 32'(s_ry), m_y[ridx]);
            chk("player_hit", 32'(s_hit), m_hit);
        end
    endtask

    task automatic model_update();
        int k;
        int nx;
        int ny;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = spx[i];
                m_y[i] = spy[i];
            end
            m_ph    = 0;
            m_div   = 0;
            m_hit   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_ph == 0) begin
                if (fs) begin
                    if (m_div == DIV - 1) begin
                        m_div = 0;
                        m_ph  = 1;
                    end else begin
                        m_div = m_div + 1;
                    end
                end
            end else if (m_ph == 1) begin
                m_px  = px;
                m_py  = py;
                m_hit = 0;
                m_ph  = 2;
            end else if (m_ph <= N + 1) begin
                k  = m_ph - 2;
                nx = ai_x(m_x[k], m_px, rnd_x, mode) & 511;
                ny = ai_y(m_y[k], m_py, rnd_y, mode) & 511;
                if (nx <= XM) m_x[k] = nx;
                if (ny <= YM) m_y[k] = ny;
`ifdef ENEMY_COLLISION_EN
                if (m_x[k] == m_px && m_y[k] == m_py) m_hit = 1;
`endif
                m_ph = m_ph + 1;
            end else begin
                m_ph = 0;
            end
        end
    endtask

    // One clock: drive inputs, check before the edge, advance model after it.
    task automatic step(input logic f, input logic r);
        fs    = f;
        rst_n = r;
        rnd_x = $urandom_range(0, 511);
        rnd_y = $urandom_range(0, 511);
        #1;
        compare();
        @(posedge clk);
        model_update();
        if (s_get) begin
            ai_px = px;
            ai_py = py;
        end
        @(negedge clk);
    endtask

    int get_at, run_first, run_cnt, done_at, bc;

    initial begin
        total   = 0;
        bad     = 0;
        m_valid = 1'b0;
        m_ph    = 0;
        m_div   = 0;
        m_hit   = 0;
        m_px    = 0;
        m_py    = 0;
        mode    = 0;
        ai_px   = 0;
        ai_py   = 0;
        rnd_x   = 0;
        rnd_y   = 0;
        ridx    = 3'd0;
        px      = 9'd0;
        py      = 9'd0;
        fs      = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        ridx = 3'd3;
        step(1'b0, 1'b1);
        chk("rst_get", 32'(s_get), 0);
        chk("rst_run", 32'(s_run), 0);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_hit", 32'(s_hit), 0);
        chk("rst_read3_x", 32'(s_rx), 319);
        chk("rst_read3_y", 32'(s_ry), 10);

        // Divide-by-two timing, chase result on slot0.
        px = 9'd114; py = 9'd104; mode = 0; ridx = 3'd0;
        step(1'b1, 1'b1);
        bc = 0;
        for (int i = 0; i < 99; i++) begin
            step(1'b0, 1'b1);
            bc += int'(s_busy);
        end
        chk("skip_first_busy", bc, 0);
        step(1'b1, 1'b1);
        get_at = 0; run_first = 0; run_cnt = 0; done_at = 0; bc = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1);
            if (s_get && get_at == 0) get_at = i;
            if (s_run) begin
                if (run_first == 0) run_first = i;
                run_cnt++;
            end
            if (s_done) done_at = i;
            bc += int'(s_busy);
        end
        chk("sweep_get_at", get_at, 1);
        chk("sweep_run_first", run_first, 2);
        chk("sweep_run_cnt", run_cnt, 8);
        chk("sweep_done_at", done_at, 10);
        chk("sweep_busy_cnt", bc, 10);
        ridx = 3'd0;
        step(1'b0, 1'b1);
        chk("chase_slot0_x", 32'(s_rx), 101);
        chk("chase_slot0_y", 32'(s_ry), 104);
        for (int i = 0; i < 86; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            bc += int'(s_busy);
        end
        chk("skip_third_busy", bc, 0);

        // Reset while slot 4 is being updated.
        step(1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        ridx = 3'd0;
        step(1'b0, 1'b1);
        chk("midreset_busy", 32'(s_busy), 0);
        chk("midreset_slot0_x", 32'(s_rx), 100);
        chk("midreset_slot0_y", 32'(s_ry), 104);

        // Out-of-range AI results are rejected per axis.
        mode = 2;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        ridx = 3'd1;
        step(1'b0, 1'b1);
        chk("underflow_x_kept", 32'(s_rx), 0);
        ridx = 3'd3;
        step(1'b0, 1'b1);
        chk("overflow_x_kept", 32'(s_rx), 319);
        chk("overflow_y", 32'(s_ry), 10);
        ridx = 3'd0;
        step(1'b0, 1'b1);
        chk("inc_slot0_x", 32'(s_rx), 101);

        // Frame start held through a sweep.
        mode = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            bc += int'(s_busy);
        end
        step(1'b0, 1'b1);
        chk("hold_busy_cnt", bc, 10);
        chk("hold_idle_after", 32'(s_busy), 0);
        step(1'b1, 1'b1);
        bc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            bc += int'(s_busy);
        end
        chk("hold_div_unchanged", bc, 0);

        // Collision flag.
        step(1'b0, 1'b0);
        px = 9'd50; py = 9'd50; mode = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
`ifdef ENEMY_COLLISION_EN
        chk("hit_set", 32'(s_hit), 1);
`else
        chk("hit_set", 32'(s_hit), 0);
`endif
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("hit_cleared", 32'(s_hit), 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            mode = $urandom_range(0, 2);
            px   = coord_t'($urandom_range(0, 330));
            py   = coord_t'($urandom_range(0, 250));
            ridx = 3'($urandom_range(0, 7));
            step($urandom_range(0, 5) == 0, $urandom_range(0, 150) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
